// File: rtl/chaos_perm_diffuse_engine.sv
// chaos_perm_diffuse_engine: keyed swap permutation + chained-XOR diffusion over an image RAM
module chaos_perm_diffuse_engine #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int KW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          decrypt,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] iv,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   skip_cnt,
    output logic [AW-1:0] img_addr,
    output logic [DW-1:0] img_wdata,
    output logic          img_we,
    input  logic [DW-1:0] img_rdata,
    output logic [AW-1:0] key_addr,
    input  logic [KW-1:0] key_rdata
);
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_PK   = 4'd1;
    localparam logic [3:0] S_PI   = 4'd2;
    localparam logic [3:0] S_PJ   = 4'd3;
    localparam logic [3:0] S_PWI  = 4'd4;
    localparam logic [3:0] S_PWJ  = 4'd5;
    localparam logic [3:0] S_DR   = 4'd6;
    localparam logic [3:0] S_DW   = 4'd7;
    localparam logic [3:0] S_DONE = 4'd8;
    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    logic [3:0]    state_q, state_d;
    logic [AW:0]   i_q, i_d, n_q, n_d, skip_q, skip_d;
    logic [AW-1:0] j_q, j_d;
    logic [DW-1:0] vi_q, vi_d, prev_q, prev_d;
    logic          dec_q, dec_d, pass_q, pass_d;

    logic [AW:0]   len_c, i_step, nxt_i;
    logic [3:0]    nxt_state;
    logic [DW-1:0] diff;
    logic          swap_st, desc, last, skip;

    // shared step bookkeeping: where the next step starts and with which index
    always_comb begin
        len_c     = (len > FULL) ? FULL : len;
        swap_st   = (state_q >= S_PK) && (state_q <= S_PWJ);
        desc      = dec_q && swap_st;
        last      = desc ? (i_q == '0) : (i_q == n_q - ONE);
        i_step    = desc ? i_q - ONE : i_q + ONE;
        skip      = ({1'b0, key_rdata[AW-1:0]} >= n_q) || ({1'b0, key_rdata[AW-1:0]} == i_q);
        diff      = img_rdata ^ key_rdata[DW-1:0] ^ prev_q;
        nxt_state = !last ? (swap_st ? S_PK : S_DR) : pass_q ? S_DONE : (dec_q ? S_PK : S_DR);
        nxt_i     = !last ? i_step : (dec_q ? n_q - ONE : '0);
    end

    // sequencer next state: swap pass and diffusion pass ordered by mode
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        n_d     = n_q;
        j_d     = j_q;
        vi_d    = vi_q;
        prev_d  = prev_q;
        dec_d   = dec_q;
        pass_d  = pass_q;
        skip_d  = skip_q;
        case (state_q)
            S_IDLE: if (start) begin
                n_d     = len_c;
                dec_d   = decrypt;
                prev_d  = iv;
                pass_d  = 1'b0;
                i_d     = '0;
                skip_d  = '0;
                state_d = (len_c == '0) ? S_DONE : (decrypt ? S_DR : S_PK);
            end
            S_PK: state_d = S_PI;
            S_PI: begin
                j_d     = key_rdata[AW-1:0];
                skip_d  = skip ? skip_q + ONE : skip_q;
                state_d = skip ? nxt_state : S_PJ;
                i_d     = skip ? nxt_i : i_q;
                pass_d  = skip ? (pass_q | last) : pass_q;
            end
            S_PJ: begin
                vi_d    = img_rdata;
                state_d = S_PWI;
            end
            S_PWI: state_d = S_PWJ;
            S_PWJ: begin
                state_d = nxt_state;
                i_d     = nxt_i;
                pass_d  = pass_q | last;
            end
            S_DR: state_d = S_DW;
            S_DW: begin
                prev_d  = dec_q ? img_rdata : diff;
                state_d = nxt_state;
                i_d     = nxt_i;
                pass_d  = pass_q | last;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state registers; reset aborts any run on the spot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            n_q     <= '0;
            j_q     <= '0;
            vi_q    <= '0;
            prev_q  <= '0;
            dec_q   <= 1'b0;
            pass_q  <= 1'b0;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            n_q     <= n_d;
            j_q     <= j_d;
            vi_q    <= vi_d;
            prev_q  <= prev_d;
            dec_q   <= dec_d;
            pass_q  <= pass_d;
            skip_q  <= skip_d;
        end
    end

    // RAM strobes decoded from the current step phase
    always_comb begin
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        done      = state_q == S_DONE;
        skip_cnt  = skip_q;
        img_we    = (state_q == S_PWI) || (state_q == S_PWJ) || (state_q == S_DW);
        img_addr  = ((state_q == S_PJ) || (state_q == S_PWJ)) ? j_q :
                    ((state_q == S_PI) || (state_q == S_PWI) || (state_q == S_DR) || (state_q == S_DW)) ? i_q[AW-1:0] : '0;
        key_addr  = ((state_q == S_PK) || (state_q == S_DR)) ? i_q[AW-1:0] : '0;
        img_wdata = (state_q == S_PWI) ? img_rdata : (state_q == S_PWJ) ? vi_q : (state_q == S_DW) ? diff : '0;
    end
endmodule

// File: tb/tb_chaos_perm_diffuse_engine.sv
// tb_chaos_perm_diffuse_engine: random and directed runs checked against an array-level cipher model
module tb_chaos_perm_diffuse_engine;
    logic        clk = 1'b0;
    logic        reset, start, decrypt;
    logic [8:0]  len;
    logic [15:0] iv;
    logic        busy, done, img_we;
    logic [8:0]  skip_cnt;
    logic [7:0]  img_addr, key_addr;
    logic [15:0] img_wdata, img_rdata, key_rdata;

    logic [15:0] img_mem [256];
    logic [15:0] key_mem [256];
    logic [15:0] exp_img [256];
    logic [15:0] orig    [256];
    logic [15:0] kmod    [256];
    logic        ld;
    logic [7:0]  ld_a;
    logic [15:0] ld_img, ld_key;

    int errors = 0;
    int checks = 0;
    int m_skip, m_tot, skip1;

    chaos_perm_diffuse_engine #(.AW(8), .DW(16), .KW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .decrypt(decrypt), .len(len), .iv(iv),
        .busy(busy), .done(done), .skip_cnt(skip_cnt), .img_addr(img_addr),
        .img_wdata(img_wdata), .img_we(img_we), .img_rdata(img_rdata),
        .key_addr(key_addr), .key_rdata(key_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        img_rdata <= img_mem[img_addr];
        key_rdata <= key_mem[key_addr];
        if (ld) begin
            img_mem[ld_a] <= ld_img;
            key_mem[ld_a] <= ld_key;
        end else if (img_we) img_mem[img_addr] <= img_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            ld = 1'b1; ld_a = 8'(i); ld_img = exp_img[i]; ld_key = kmod[i];
        end
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic randomize_arrays();
        for (int i = 0; i < 256; i++) begin
            exp_img[i] = 16'($urandom);
            kmod[i]    = 16'($urandom);
        end
    endtask

    // what the image must become: plain array swaps and XOR chaining
    task automatic model(input bit dec, input int n, input logic [15:0] ivv);
        logic [15:0] prev, t;
        int s;
        s = 0;
        if (dec) begin
            prev = ivv;
            for (int i = 0; i < n; i++) begin
                t = exp_img[i];
                exp_img[i] = t ^ kmod[i] ^ prev;
                prev = t;
            end
        end
        for (int q = 0; q < n; q++) begin
            int i = dec ? n - 1 - q : q;
            int j = int'(kmod[i][7:0]);
            if (j >= n || j == i) s++;
            else begin
                t = exp_img[i];
                exp_img[i] = exp_img[j];
                exp_img[j] = t;
            end
        end
        if (!dec) begin
            prev = ivv;
            for (int i = 0; i < n; i++) begin
                exp_img[i] = exp_img[i] ^ kmod[i] ^ prev;
                prev = exp_img[i];
            end
        end
        m_skip = s;
        m_tot  = 2 + 7 * n - 3 * s;
    endtask

    task automatic run(input bit dec, input logic [8:0] l, input logic [15:0] ivv, input bit poke);
        int n, pk, bad;
        n = (l > 9'd256) ? 256 : int'(l);
        model(dec, n, ivv);
        pk = !poke ? -1 : (m_tot > 2) ? 1 + int'($urandom_range(m_tot - 3, 0)) : 1;
        @(negedge clk);
        decrypt = dec; len = l; iv = ivv; start = 1'b1;
        for (int k = 1; k <= m_tot + 2; k++) begin
            @(negedge clk);
            start = (k == pk) || (k == m_tot - 1);
            if (k == 1) begin
                decrypt = ~dec; len = 9'($urandom); iv = 16'($urandom);
            end
            chk("busy", busy, k <= m_tot - 2);
            chk("done", done, k == m_tot - 1);
            if (!busy) chk("we_idle", img_we, 0);
        end
        start = 1'b0;
        chk("skip_cnt", skip_cnt, m_skip);
        bad = 0;
        for (int i = 0; i < 256; i++) if (img_mem[i] !== exp_img[i]) bad++;
        chk("image_mismatches", bad, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; decrypt = 1'b0; len = '0; iv = '0; ld = 1'b0; ld_a = '0; ld_img = '0; ld_key = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", img_we, 0);
        chk("rst_img_addr", img_addr, 0);
        chk("rst_key_addr", key_addr, 0);
        chk("rst_wdata", img_wdata, 0);
        chk("rst_skip", skip_cnt, 0);
        reset = 1'b0;

        for (int i = 0; i < 256; i++) begin
            exp_img[i] = '0;
            kmod[i] = 16'(i);
        end
        load();
        run(1'b0, 9'd8, 16'h0, 1'b0);
        chk("t1_skip", skip_cnt, 8);
        chk("t1_tot", m_tot, 34);
        chk("t1_w2", img_mem[2], 16'h3);
        chk("t1_w6", img_mem[6], 16'h7);
        chk("t1_w7", img_mem[7], 16'h0);

        for (int i = 0; i < 4; i++) begin
            exp_img[i] = 16'(10 + i);
            kmod[i] = 16'(3 - i);
        end
        load();
        run(1'b0, 9'd4, 16'h0, 1'b0);
        chk("t2_tot", m_tot, 30);
        chk("t2_w0", img_mem[0], 16'h9);
        chk("t2_w1", img_mem[1], 16'h0);
        chk("t2_w2", img_mem[2], 16'hD);
        chk("t2_w3", img_mem[3], 16'h0);
        chk("t2_model2", exp_img[2], 16'hD);

        randomize_arrays();
        for (int i = 0; i < 256; i++) orig[i] = exp_img[i];
        load();
        run(1'b0, 9'd256, 16'h5A5A, 1'b1);
        skip1 = m_skip;
        run(1'b1, 9'd256, 16'h5A5A, 1'b1);
        chk("t3_skip_equal", skip_cnt, skip1);
        begin
            int bad = 0;
            for (int i = 0; i < 256; i++) if (img_mem[i] !== orig[i]) bad++;
            chk("t3_restore", bad, 0);
        end

        run(1'b0, 9'd0, 16'h1234, 1'b0);
        chk("t4_tot", m_tot, 2);
        randomize_arrays();
        load();
        run(1'b1, 9'd300, 16'($urandom), 1'b1);
        chk("t4_clamp_tot", m_tot, 2 + 7 * 256 - 3 * m_skip);

        randomize_arrays();
        for (int i = 0; i < 16; i++) kmod[i] = 16'(15 - i);
        load();
        @(negedge clk);
        decrypt = 1'b0; len = 9'd16; iv = 16'($urandom); start = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("t5_pwi_we", img_we, 1);
        chk("t5_pwi_addr", img_addr, 4);
        reset = 1'b1;
        #1;
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_we", img_we, 0);
        chk("t5_abort_skip", skip_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        randomize_arrays();
        load();
        run(1'b0, 9'd16, 16'($urandom), 1'b0);

        for (int r = 0; r < 4; r++) begin
            randomize_arrays();
            load();
            run(1'($urandom), 9'($urandom_range(300, 1)), 16'($urandom), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
